// File: rtl/int_arith_pkg.sv
// Shared definitions for the integer arithmetic unit (multiplier and divider).
package int_arith_pkg;

    // Default operand width shared by the multiplier and the divider
    localparam int INT_ARITH_WIDTH = 8;

    // Multiplier control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/int_mul_step.sv
// One shift-add multiplication iteration, purely combinational.
// The multiplicand is widened to the full product width so the shifted
// copy never loses bits; the accumulator therefore cannot overflow.
module int_mul_step
    import int_arith_pkg::*;
#(
    parameter int WIDTH = INT_ARITH_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplr,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic [2*WIDTH-1:0] mcand_nxt,
    output logic [WIDTH-1:0]   mplr_nxt
);

    // Add the shifted multiplicand when the current multiplier LSB is set
    always_comb begin
        acc_nxt   = mplr[0] ? (acc + mcand) : acc;
        mcand_nxt = mcand << 1;
        mplr_nxt  = mplr >> 1;
    end

endmodule

// File: rtl/int_multiplier.sv
// Iterative shift-add integer multiplier with valid/ready operand handshake.
// One multiplier bit is consumed per cycle; the operation finishes early as
// soon as the remaining multiplier bits are all zero, and a zero operand
// skips iteration altogether.
// Optional build macro SIGNED_MUL_EN: treat operands as two's complement
// (iterate on magnitudes, negate the result when the signs differ).
module int_multiplier
    import int_arith_pkg::*;
#(
    parameter int WIDTH    = INT_ARITH_WIDTH,
    parameter int LOGWIDTH = $clog2(WIDTH)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 DataVal,
    output logic                 DataRdy,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 ResultVal
);

    localparam int PW = 2 * WIDTH;

    mul_state_t          state_q, state_d;
    logic [PW-1:0]       acc_q, acc_d;
    logic [PW-1:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplr_q, mplr_d;
    logic [LOGWIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]       product_q, product_d;

    logic                accept;
    logic                op_zero;
    logic                last_iter;
    logic [WIDTH-1:0]    mcand_in;
    logic [WIDTH-1:0]    mplr_in;
    logic [PW-1:0]       final_acc;

    logic [PW-1:0]       acc_step;
    logic [PW-1:0]       mcand_step;
    logic [WIDTH-1:0]    mplr_step;

    int_mul_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc       (acc_q),
        .mcand     (mcand_q),
        .mplr      (mplr_q),
        .acc_nxt   (acc_step),
        .mcand_nxt (mcand_step),
        .mplr_nxt  (mplr_step)
    );

`ifdef SIGNED_MUL_EN
    logic sign_q, sign_d;

    // Magnitude of a two's complement operand; the most negative value maps
    // onto its unsigned equivalent 2^(WIDTH-1), which still fits.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
    endfunction

    // Reapply the result sign to an unsigned magnitude product
    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] p, input logic neg);
        return neg ? (-p) : p;
    endfunction

    // Operand magnitudes and result sign seen at the accept edge
    always_comb begin
        mcand_in  = magnitude(Multiplicand);
        mplr_in   = magnitude(Multiplier);
        sign_d    = accept ? (Multiplicand[WIDTH-1] ^ Multiplier[WIDTH-1]) : sign_q;
        final_acc = apply_sign(acc_step, sign_q);
    end

    // Result sign register, captured with the operands
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) sign_q <= 1'b0;
        else        sign_q <= sign_d;
    end
`else
    // Unsigned operands feed the datapath directly
    always_comb begin
        mcand_in  = Multiplicand;
        mplr_in   = Multiplier;
        final_acc = acc_step;
    end
`endif

    // Handshake and iteration-exit conditions
    always_comb begin
        accept    = DataVal & DataRdy;
        op_zero   = (mcand_in == '0) || (mplr_in == '0);
        last_iter = (mplr_step == '0) || (cnt_q == LOGWIDTH'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; DONE falls back to IDLE unless a new operand pair arrives
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) state_d = op_zero ? DONE : BUSY;
                else        state_d = IDLE;
            end
            BUSY: begin
                if (last_iter) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        DataRdy   = (state_q == IDLE) || (state_q == DONE);
        ResultVal = (state_q == DONE);
        Product   = product_q;
    end

    // Datapath next values: load on accept, iterate in BUSY, publish on exit
    always_comb begin
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (accept) begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, mcand_in};
            mplr_d  = mplr_in;
            cnt_d   = '0;
            if (op_zero) product_d = '0;
        end else if (state_q == BUSY) begin
            acc_d   = acc_step;
            mcand_d = mcand_step;
            mplr_d  = mplr_step;
            cnt_d   = cnt_q + LOGWIDTH'(1);
            if (last_iter) product_d = final_acc;
        end
    end

    // Datapath registers, all cleared by reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_int_multiplier.sv
// Bench for int_multiplier (WIDTH=8): directed operand pairs with literal
// expected products and latencies, plus a cycle-by-cycle reference model.
module tb_int_multiplier;

    localparam int W = 8;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic           DataVal = 1'b0;
    logic [W-1:0]   Multiplicand = '0;
    logic [W-1:0]   Multiplier = '0;
    logic           DataRdy;
    logic [2*W-1:0] Product;
    logic           ResultVal;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [15:0] prod;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] hold;

    int_multiplier #(.WIDTH(W)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .DataVal      (DataVal),
        .DataRdy      (DataRdy),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Product      (Product),
        .ResultVal    (ResultVal)
    );

    always #5 CLK = ~CLK;

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Arithmetic product, truncated to 16 bits
    function automatic logic [15:0] model_prod(input logic [7:0] a, input logic [7:0] b);
        int pa, pb, p;
`ifdef SIGNED_MUL_EN
        pa = int'($signed(a));
        pb = int'($signed(b));
`else
        pa = int'(a);
        pb = int'(b);
`endif
        p = pa * pb;
        return p[15:0];
    endfunction

    // Cycles from accept edge to the ResultVal cycle
    function automatic int model_lat(input logic [7:0] a, input logic [7:0] b);
        int ma, mb, k;
`ifdef SIGNED_MUL_EN
        ma = int'($signed(a));
        mb = int'($signed(b));
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`else
        ma = int'(a);
        mb = int'(b);
`endif
        if (ma == 0 || mb == 0) return 1;
        k = 0;
        while ((mb >> (k + 1)) != 0) k++;
        return k + 2;
    endfunction

    // Reference model and per-cycle compare
    initial begin
        bit exp_rv;
        bit exp_rdy;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                exp_q.delete();
                hold = '0;
                chk("rst_resultval", 32'(ResultVal), 32'(1'b0));
                chk("rst_datardy", 32'(DataRdy), 32'(1'b1));
                chk("rst_product", 32'(Product), 32'h0);
            end else begin
                exp_rv  = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                exp_rdy = !((exp_q.size() > 0) && (exp_q[0].due > cyc));
                if (exp_rv) begin
                    hold = exp_q[0].prod;
                    void'(exp_q.pop_front());
                end
                chk("model_resultval", 32'(ResultVal), 32'(exp_rv));
                chk("model_datardy", 32'(DataRdy), 32'(exp_rdy));
                chk("model_product", 32'(Product), 32'(hold));
                if (DataVal && exp_rdy)
                    exp_q.push_back('{due: cyc + model_lat(Multiplicand, Multiplier),
                                      prod: model_prod(Multiplicand, Multiplier)});
            end
        end
    end

    // Present operands for one cycle; returns #1 into cycle 1 after the accept edge
    task automatic start(input logic [7:0] a, input logic [7:0] b);
        @(posedge CLK); #1;
        DataVal = 1'b1;
        Multiplicand = a;
        Multiplier = b;
        @(posedge CLK); #1;
        DataVal = 1'b0;
    endtask

    // Wait (bounded) for ResultVal and pin latency and product to literals
    task automatic wait_rv(input string nm, input int lat, input logic [15:0] p);
        int n;
        n = 1;
        while (!ResultVal && n <= 20) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(lat));
        chk({nm, "_product"}, 32'(Product), 32'(p));
    endtask

    task automatic op(input string nm, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] p, input int lat);
        start(a, b);
        wait_rv(nm, lat, p);
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;

        op("13x11", 8'd13, 8'd11, 16'h008F, 5);
        op("255x255", 8'hFF, 8'hFF, 16'hFE01, 9);
        op("0x200", 8'd0, 8'd200, 16'h0000, 1);
        op("200x0", 8'd200, 8'd0, 16'h0000, 1);

        // Back-to-back: new operands presented during the DONE cycle
        start(8'd13, 8'd11);
        wait_rv("b2b_first", 5, 16'h008F);
        DataVal = 1'b1;
        Multiplicand = 8'd7;
        Multiplier = 8'd1;
        @(posedge CLK); #1;
        DataVal = 1'b0;
        wait_rv("b2b_second", 2, 16'h0007);

        // Reset in cycle 3 of a long operation
        start(8'hFF, 8'hFF);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        #1;
        chk("abort_resultval", 32'(ResultVal), 32'(1'b0));
        chk("abort_product", 32'(Product), 32'h0);
        chk("abort_datardy", 32'(DataRdy), 32'(1'b1));
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (ResultVal) seen++;
        end
        chk("abort_no_result", 32'(seen), 32'h0);
        op("2x3", 8'd2, 8'd3, 16'h0006, 3);

`ifdef SIGNED_MUL_EN
        op("fdx05", 8'hFD, 8'h05, 16'hFFF1, 4);
`else
        op("fdx05", 8'hFD, 8'h05, 16'h04F1, 4);
`endif
        op("80x80", 8'h80, 8'h80, 16'h4000, 9);
        op("1x1", 8'd1, 8'd1, 16'h0001, 2);

        repeat (3) @(posedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
